// File: rtl/pixel_arb_pkg.sv
// Shared types and constants for the display BRAM pixel write arbiter.
package pixel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_1 = 2'd1,
        OWN_2 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_MD1  = 2'b01;
    localparam logic [1:0] OWN_MD2  = 2'b10;

    // 540 x 540 display frame
    localparam int unsigned FRAME_PIXELS_DEF = 291600;

    function automatic logic [1:0] owner_of(arb_state_t s);
        logic [1:0] o;
        o = OWN_NONE;
        if (s == OWN_1) o = OWN_MD1;
        if (s == OWN_2) o = OWN_MD2;
        return o;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small per-source pixel FIFO: push/pop, push-while-full-with-pop, synchronous flush.
module pixel_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_c,
    output logic              empty_c,
    output logic              full_c
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pixel_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign empty_c = (cnt_q == '0);
    assign full_c  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign head_c  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && (!full_c || pop_i) && !flush_i;
        do_pop   = pop_i && !empty_c && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pixel_wr_arbiter.sv
// Frame-granular arbiter between the mode-1 passthrough and the Sobel core,
// writing one source's frame at a time into display BRAM port A.
module pixel_wr_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] md1_pixel_i,
    input  logic              md1_pixel_en_i,
    input  logic [DATA_W-1:0] md2_pixel_i,
    input  logic              md2_pixel_en_i,
    input  logic              abort_i,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [DATA_W-1:0] d2mema_o,
    output logic [1:0]        owner_o,
    output logic              frame_done_o,
    output logic              md1_ovf_o,
    output logic              md2_ovf_o
);

    localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    if (FRAME_PIXELS == 0 || 64'(FRAME_PIXELS) > ADDR_SPAN) begin : g_bad_frame
        $error("pixel_wr_arbiter: FRAME_PIXELS must be in 1..2^ADDR_W");
    end

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rr_last_md2_q, rr_last_md2_d;
    logic              ena_q, ena_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        owner_q, owner_d;
    logic              done_q, done_d;
    logic              ovf1_q, ovf1_d;
    logic              ovf2_q, ovf2_d;

    logic              pop1, pop2, push1, push2;
    logic              empty1, empty2, full1, full2;
    logic [DATA_W-1:0] head1, head2;

    pixel_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_md1 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (abort_i),
        .push_i  (push1),
        .pop_i   (pop1),
        .data_i  (md1_pixel_i),
        .head_c  (head1),
        .empty_c (empty1),
        .full_c  (full1)
    );

    pixel_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_md2 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (abort_i),
        .push_i  (push2),
        .pop_i   (pop2),
        .data_i  (md2_pixel_i),
        .head_c  (head2),
        .empty_c (empty2),
        .full_c  (full2)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_last_md2_d = rr_last_md2_q;
        ena_d         = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;
        done_d        = 1'b0;
        pop1          = 1'b0;
        pop2          = 1'b0;

        // In IDLE a tie goes to whichever source did not own the last frame
        case (state_q)
            IDLE: begin
                if (!empty1 && (empty2 || rr_last_md2_q)) pop1 = 1'b1;
                else if (!empty2)                         pop2 = 1'b1;
            end
            OWN_1:   pop1 = !empty1;
            OWN_2:   pop2 = !empty2;
            default: state_d = IDLE;
        endcase

        if (pop1 || pop2) begin
            ena_d  = 1'b1;
            addr_d = cnt_q;
            data_d = pop1 ? head1 : head2;
            if (cnt_q == LAST_ADDR) begin
                cnt_d         = '0;
                done_d        = 1'b1;
                state_d       = IDLE;
                rr_last_md2_d = pop2;
            end else begin
                cnt_d   = cnt_q + ADDR_W'(1);
                state_d = pop1 ? OWN_1 : OWN_2;
            end
        end

        push1  = md1_pixel_en_i && (!full1 || pop1);
        push2  = md2_pixel_en_i && (!full2 || pop2);
        ovf1_d = ovf1_q || (md1_pixel_en_i && full1 && !pop1);
        ovf2_d = ovf2_q || (md2_pixel_en_i && full2 && !pop2);

        // Abort wins over everything except the round-robin history
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            ena_d   = 1'b0;
            done_d  = 1'b0;
            ovf1_d  = 1'b0;
            ovf2_d  = 1'b0;
            pop1    = 1'b0;
            pop2    = 1'b0;
            push1   = 1'b0;
            push2   = 1'b0;
        end

        owner_d = owner_of(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rr_last_md2_q <= 1'b1;
            ena_q         <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            owner_q       <= OWN_NONE;
            done_q        <= 1'b0;
            ovf1_q        <= 1'b0;
            ovf2_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_last_md2_q <= rr_last_md2_d;
            ena_q         <= ena_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            owner_q       <= owner_d;
            done_q        <= done_d;
            ovf1_q        <= ovf1_d;
            ovf2_q        <= ovf2_d;
        end
    end

    assign ena_o        = ena_q;
    assign wea_o        = ena_q;
    assign addra_o      = addr_q;
    assign d2mema_o     = data_q;
    assign owner_o      = owner_q;
    assign frame_done_o = done_q;
    assign md1_ovf_o    = ovf1_q;
    assign md2_ovf_o    = ovf2_q;

endmodule
